// File: rtl/cropper_if.sv
// Video stream bundle for the window cropper: raw input side,
// cropped output side and the crop-mode enable.
interface cropper_if;
    logic        en;
    logic        pre_vs;
    logic        pre_de;
    logic [23:0] pre_data;
    logic        post_vs;
    logic        post_de;
    logic [23:0] post_data;
    logic        short_line;

    modport master (
        output en, pre_vs, pre_de, pre_data,
        input  post_vs, post_de, post_data, short_line
    );

    modport slave (
        input  en, pre_vs, pre_de, pre_data,
        output post_vs, post_de, post_data, short_line
    );
endinterface

// File: rtl/cropper.sv
// Window cropper for RGB888 vs/de/data video: keeps an H_DISP x V_DISP
// window at (H_OFFSET, V_OFFSET) and flags lines too short to fill it.
module cropper #(
    parameter logic [11:0] H_DISP   = 12'd1280,
    parameter logic [11:0] V_DISP   = 12'd720,
    parameter logic [11:0] H_OFFSET = 12'd0,
    parameter logic [11:0] V_OFFSET = 12'd0
) (
    input logic      clk,
    input logic      rst_n,
    cropper_if.slave vid
);

    typedef enum logic [1:0] {IDLE, HSKIP, PASS, HDROP} state_t;

    localparam logic [11:0] H_LEN     = H_OFFSET + H_DISP;
    localparam logic [11:0] H_END     = H_LEN - 12'd1;
    localparam logic [11:0] SKIP_LAST = H_OFFSET - 12'd1;
    localparam logic [11:0] V_END     = V_OFFSET + V_DISP - 12'd1;

    state_t      state, state_d;
    logic [11:0] x_cnt, x_d;
    logic [11:0] y_cnt, y_d;
    logic        armed, armed_d;
    logic        de_d;
    logic        de_nx, short_nx, out_pix;
    logic [23:0] data_nx;
    logic        y_in, line_end;

    assign y_in     = (y_cnt >= V_OFFSET) && (y_cnt <= V_END);
    assign line_end = de_d & ~vid.pre_de;

    always_comb begin
        state_d  = state;
        x_d      = x_cnt;
        y_d      = y_cnt;
        armed_d  = armed;
        de_nx    = 1'b0;
        data_nx  = '0;
        short_nx = 1'b0;
        out_pix  = 1'b0;
        if (!vid.en) begin
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            armed_d = 1'b0;
            de_nx   = vid.pre_de;
            data_nx = vid.pre_data;
        end else if (vid.pre_vs) begin
            // Frame start wins over any line end in the same cycle
            state_d = IDLE;
            x_d     = '0;
            y_d     = '0;
            armed_d = 1'b1;
        end else begin
            if (!vid.pre_de)
                x_d = '0;
            else if (x_cnt != 12'hFFF)
                x_d = x_cnt + 12'd1;
            if (line_end && y_cnt != 12'hFFF)
                y_d = y_cnt + 12'd1;
            short_nx = line_end & armed & y_in & (x_cnt < H_LEN);
            unique case (state)
                IDLE: begin
                    if (vid.pre_de) begin
                        if (H_OFFSET == 12'd0) begin
                            out_pix = 1'b1;
                            state_d = (H_DISP == 12'd1) ? HDROP : PASS;
                        end else begin
                            state_d = (H_OFFSET == 12'd1) ? PASS : HSKIP;
                        end
                    end
                end
                HSKIP: begin
                    if (!vid.pre_de)
                        state_d = IDLE;
                    else if (x_cnt == SKIP_LAST)
                        state_d = PASS;
                end
                PASS: begin
                    if (!vid.pre_de) begin
                        state_d = IDLE;
                    end else begin
                        out_pix = 1'b1;
                        if (x_cnt == H_END)
                            state_d = HDROP;
                    end
                end
                HDROP: begin
                    if (!vid.pre_de)
                        state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
            if (out_pix && armed && y_in) begin
                de_nx   = 1'b1;
                data_nx = vid.pre_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            x_cnt          <= '0;
            y_cnt          <= '0;
            armed          <= 1'b0;
            de_d           <= 1'b0;
            vid.post_vs    <= 1'b0;
            vid.post_de    <= 1'b0;
            vid.post_data  <= '0;
            vid.short_line <= 1'b0;
        end else begin
            state          <= state_d;
            x_cnt          <= x_d;
            y_cnt          <= y_d;
            armed          <= armed_d;
            de_d           <= vid.pre_de;
            vid.post_vs    <= vid.pre_vs;
            vid.post_de    <= de_nx;
            vid.post_data  <= data_nx;
            vid.short_line <= short_nx;
        end
    end

endmodule

// File: tb/tb_cropper.sv
// Self-checking bench for cropper: directed and random frames against
// a line-level window model, plus a default-size saturation check.
module tb_cropper;

    localparam logic [11:0] HD = 12'd4;
    localparam logic [11:0] VD = 12'd2;
    localparam logic [11:0] HO = 12'd2;
    localparam logic [11:0] VO = 12'd1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cropper_if a ();
    cropper_if b ();

    assign b.en       = a.en;
    assign b.pre_vs   = a.pre_vs;
    assign b.pre_de   = a.pre_de;
    assign b.pre_data = a.pre_data;

    cropper #(
        .H_DISP(HD), .V_DISP(VD), .H_OFFSET(HO), .V_OFFSET(VO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .vid(a.slave)
    );

    cropper dut_def (
        .clk(clk), .rst_n(rst_n), .vid(b.slave)
    );

    int compared = 0;
    int mismatched = 0;
    bit en_m = 1'b0;
    bit armed_m = 1'b0;
    int y_m = 0;

    int de_cnt2 = 0;
    int sh_cnt2 = 0;
    always @(posedge clk) begin
        if (b.post_de) de_cnt2 <= de_cnt2 + 1;
        if (b.short_line) sh_cnt2 <= sh_cnt2 + 1;
    end

    function automatic bit y_in(input int y);
        return (y >= int'(VO)) && (y < int'(VO) + int'(VD));
    endfunction

    task automatic check_out(input logic vs, input logic de,
                             input logic [23:0] d, input logic sh,
                             input string tag);
        compared++;
        assert ({a.post_vs, a.post_de, a.post_data, a.short_line} ===
                {vs, de, d, sh})
        else begin
            mismatched++;
            $error("FAIL %s: observed vs=%b de=%b data=%h short=%b required vs=%b de=%b data=%h short=%b",
                   tag, a.post_vs, a.post_de, a.post_data, a.short_line,
                   vs, de, d, sh);
        end
    endtask

    task automatic step(input logic vs, input logic de,
                        input logic [23:0] d, input logic ede,
                        input logic [23:0] ed, input logic esh,
                        input string tag);
        a.pre_vs = vs;
        a.pre_de = de;
        a.pre_data = d;
        @(posedge clk);
        #1;
        check_out(vs, ede, ed, esh, tag);
    endtask

    task automatic set_en(input bit v);
        a.en = v;
        en_m = v;
        if (!v) armed_m = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, "idle");
    endtask

    task automatic vsync();
        step(1, 0, 0, 0, 0, 0, "vsync");
        armed_m = en_m;
        y_m = 0;
        idle(1);
    endtask

    function automatic bit in_win(input int x);
        return armed_m && y_in(y_m) && x >= int'(HO) && x < int'(HO + HD);
    endfunction

    // Drives n pixels of a line, optionally without its end cycle
    task automatic pixels(input int x0, input int n, input int base,
                          input bit rnd, input string tag);
        logic [23:0] d;
        bit o;
        for (int x = x0; x < x0 + n; x++) begin
            d = rnd ? 24'($urandom) : 24'(base + x + 1);
            if (!en_m) begin
                step(0, 1, d, 1, d, 0, tag);
            end else begin
                o = in_win(x);
                step(0, 1, d, o, o ? d : 24'd0, 0, tag);
            end
        end
    endtask

    task automatic line(input int n, input int base, input bit rnd,
                        input string tag);
        bit sh;
        pixels(0, n, base, rnd, tag);
        sh = en_m && armed_m && y_in(y_m) && n < int'(HO + HD);
        step(0, 0, 0, 0, 0, sh, {tag, "_end"});
        y_m++;
        idle(1);
    endtask

    task automatic frame4();
        for (int l = 0; l < 4; l++) line(8, 16 * l, 0, "crop");
    endtask

    int c0, s0;

    initial begin
        a.en = 1'b0;
        a.pre_vs = 1'b0;
        a.pre_de = 1'b0;
        a.pre_data = '0;
        #12;
        check_out(0, 0, 0, 0, "reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);

        // Passthrough
        set_en(0);
        line(8, 0, 0, "pass");

        // Normal crop
        set_en(1);
        vsync();
        frame4();

        // Short line
        vsync();
        line(8, 0, 0, "short0");
        line(4, 16, 0, "short1");

        // Arming: enable mid-line within a frame
        set_en(0);
        vsync();
        for (int x = 0; x < 8; x++) begin
            if (x == 3) set_en(1);
            step(0, 1, 24'(x + 1), !en_m, en_m ? 24'd0 : 24'(x + 1), 0,
                 "arm_mid");
        end
        step(0, 0, 0, 0, 0, 0, "arm_end");
        y_m = 1;
        idle(1);
        line(8, 32, 0, "arm_l2");
        line(8, 48, 0, "arm_l3");
        vsync();
        frame4();

        // Abort by pre_vs during PASS
        vsync();
        line(8, 0, 0, "abort0");
        pixels(0, 4, 16, 0, "abort1");
        step(1, 0, 0, 0, 0, 0, "abort_vs");
        armed_m = 1'b1;
        y_m = 0;
        idle(2);
        frame4();

        // Async reset during PASS
        vsync();
        line(8, 0, 0, "rst0");
        pixels(0, 4, 16, 0, "rst1");
        a.pre_data = 24'hABCDEF;
        #2;
        rst_n = 1'b0;
        #1;
        check_out(0, 0, 0, 0, "rst_async");
        @(posedge clk);
        #1;
        check_out(0, 0, 0, 0, "rst_hold");
        a.pre_de = 1'b0;
        rst_n = 1'b1;
        armed_m = 1'b0;
        y_m = 0;
        idle(1);
        line(8, 16, 0, "rst_noarm");
        line(8, 32, 0, "rst_noarm");
        vsync();
        frame4();

        // Random frames
        for (int f = 0; f < 4; f++) begin
            vsync();
            for (int l = 0; l < int'($urandom_range(1, 4)); l++) begin
                line(int'($urandom_range(1, 10)), 0, 1, "rand");
                idle(int'($urandom_range(0, 2)));
            end
        end

        // Saturation on the default-size instance
        vsync();
        c0 = de_cnt2;
        s0 = sh_cnt2;
        line(5000, 0, 1, "sat");
        compared++;
        assert ((de_cnt2 - c0) === 1280)
        else begin
            mismatched++;
            $error("FAIL sat_count: observed %0d required %0d",
                   de_cnt2 - c0, 1280);
        end
        compared++;
        assert ((sh_cnt2 - s0) === 0)
        else begin
            mismatched++;
            $error("FAIL sat_short: observed %0d required %0d",
                   sh_cnt2 - s0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
